// File: rtl/cv32e40p_nmr_voter.sv
// N-modular-redundancy voter: registered bitwise majority over the non-broken replicas,
// with leaky per-channel mismatch counters that retire persistently faulty channels.
module cv32e40p_nmr_voter #(
    parameter int N_CH        = 3,
    parameter int WIDTH       = 32,
    parameter int ERR_THRESH  = 8,
    parameter int LEAK_PERIOD = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [N_CH*WIDTH-1:0] data_i,
    input  logic [N_CH-1:0]       set_broken_i,
    input  logic [N_CH-1:0]       clear_broken_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  valid_o,
    output logic                  err_detected_o,
    output logic                  err_corrected_o,
    output logic                  err_uncorrectable_o,
    output logic [N_CH-1:0]       is_broken_o,
    output logic                  degraded_o,
    output logic                  fatal_o
);

    localparam int CW = $clog2(ERR_THRESH + 1);
    localparam int LW = $clog2(LEAK_PERIOD + 1);
    localparam logic [CW-1:0] THRESH = CW'(ERR_THRESH);
    localparam logic [LW-1:0] LEAK   = LW'(LEAK_PERIOD);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             det_q, det_d;
    logic             cor_q, cor_d;
    logic             unc_q, unc_d;
    logic [N_CH-1:0]  broken_q, broken_d;
    logic             degraded_q, degraded_d;
    logic             fatal_q, fatal_d;
    logic [CW-1:0]    mis_cnt_q [N_CH];
    logic [CW-1:0]    mis_cnt_d [N_CH];
    logic [LW-1:0]    leak_cnt_q [N_CH];
    logic [LW-1:0]    leak_cnt_d [N_CH];

    logic [WIDTH-1:0] vote;
    logic [WIDTH-1:0] tie_bits;
    logic [N_CH-1:0]  ch_mismatch;
    int               n_act;
    int               ones;
    int               zeros;
    logic             first_bit;
    logic             found;

    // With an empty active set every bit looks like a tie; it is forced to 0 and not flagged.
    always_comb begin
        vote        = '0;
        tie_bits    = '0;
        ch_mismatch = '0;
        n_act       = 0;
        ones        = 0;
        zeros       = 0;
        first_bit   = 1'b0;
        found       = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (!broken_q[k]) n_act = n_act + 1;
        end
        for (int b = 0; b < WIDTH; b++) begin
            ones      = 0;
            zeros     = 0;
            first_bit = 1'b0;
            found     = 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                if (!broken_q[k]) begin
                    if (data_i[k*WIDTH+b]) ones = ones + 1;
                    else                   zeros = zeros + 1;
                    if (!found) begin
                        first_bit = data_i[k*WIDTH+b];
                        found     = 1'b1;
                    end
                end
            end
            if (2 * ones > n_act) begin
                vote[b] = 1'b1;
            end else if (2 * zeros > n_act) begin
                vote[b] = 1'b0;
            end else if (n_act != 0) begin
                vote[b]     = first_bit;
                tie_bits[b] = 1'b1;
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            ch_mismatch[k] = !broken_q[k] && (data_i[k*WIDTH +: WIDTH] != vote);
        end
    end

    always_comb begin
        data_d     = data_q;
        valid_d    = valid_i;
        det_d      = 1'b0;
        cor_d      = 1'b0;
        unc_d      = 1'b0;
        broken_d   = broken_q;
        mis_cnt_d  = mis_cnt_q;
        leak_cnt_d = leak_cnt_q;
        if (valid_i) begin
            data_d = vote;
            det_d  = |ch_mismatch;
            unc_d  = |tie_bits;
            cor_d  = (|ch_mismatch) && !(|tie_bits);
            for (int k = 0; k < N_CH; k++) begin
                if (!broken_q[k]) begin
                    if (ch_mismatch[k]) begin
                        leak_cnt_d[k] = '0;
                        if (mis_cnt_q[k] < THRESH) mis_cnt_d[k] = mis_cnt_q[k] + CW'(1);
                        if (mis_cnt_d[k] == THRESH) broken_d[k] = 1'b1;
                    end else if (leak_cnt_q[k] + LW'(1) == LEAK) begin
                        leak_cnt_d[k] = '0;
                        if (mis_cnt_q[k] != '0) mis_cnt_d[k] = mis_cnt_q[k] - CW'(1);
                    end else begin
                        leak_cnt_d[k] = leak_cnt_q[k] + LW'(1);
                    end
                end
            end
        end
        // Set is applied after clear so it wins when both target the same channel.
        for (int k = 0; k < N_CH; k++) begin
            if (clear_broken_i[k]) begin
                broken_d[k]   = 1'b0;
                mis_cnt_d[k]  = '0;
                leak_cnt_d[k] = '0;
            end
            if (set_broken_i[k]) broken_d[k] = 1'b1;
        end
        degraded_d = |broken_d;
        fatal_d    = &broken_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            det_q      <= 1'b0;
            cor_q      <= 1'b0;
            unc_q      <= 1'b0;
            broken_q   <= '0;
            degraded_q <= 1'b0;
            fatal_q    <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                mis_cnt_q[k]  <= '0;
                leak_cnt_q[k] <= '0;
            end
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            det_q      <= det_d;
            cor_q      <= cor_d;
            unc_q      <= unc_d;
            broken_q   <= broken_d;
            degraded_q <= degraded_d;
            fatal_q    <= fatal_d;
            for (int k = 0; k < N_CH; k++) begin
                mis_cnt_q[k]  <= mis_cnt_d[k];
                leak_cnt_q[k] <= leak_cnt_d[k];
            end
        end
    end

    assign data_o              = data_q;
    assign valid_o             = valid_q;
    assign err_detected_o      = det_q;
    assign err_corrected_o     = cor_q;
    assign err_uncorrectable_o = unc_q;
    assign is_broken_o         = broken_q;
    assign degraded_o          = degraded_q;
    assign fatal_o             = fatal_q;

endmodule

// File: tb/tb_cv32e40p_nmr_voter.sv
// Directed bench for the NMR voter: 3 channels, ERR_THRESH=4, LEAK_PERIOD=4, with
// hand-computed expectations for voting, retirement, leak, ties and control inputs.
module tb_cv32e40p_nmr_voter;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [95:0] data_i;
    logic [2:0]  set_broken_i;
    logic [2:0]  clear_broken_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        err_detected_o;
    logic        err_corrected_o;
    logic        err_uncorrectable_o;
    logic [2:0]  is_broken_o;
    logic        degraded_o;
    logic        fatal_o;

    int check_count = 0;
    int pass_count  = 0;

    cv32e40p_nmr_voter #(
        .N_CH(3), .WIDTH(32), .ERR_THRESH(4), .LEAK_PERIOD(4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .valid_i            (valid_i),
        .data_i             (data_i),
        .set_broken_i       (set_broken_i),
        .clear_broken_i     (clear_broken_i),
        .data_o             (data_o),
        .valid_o            (valid_o),
        .err_detected_o     (err_detected_o),
        .err_corrected_o    (err_corrected_o),
        .err_uncorrectable_o(err_uncorrectable_o),
        .is_broken_o        (is_broken_o),
        .degraded_o         (degraded_o),
        .fatal_o            (fatal_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        else
            pass_count++;
    endtask

    // Inputs are driven 1 time unit after a rising edge, so outputs are read well clear of it.
    task automatic applyStimulus(input logic v, input logic [31:0] d2, input logic [31:0] d1,
                                 input logic [31:0] d0, input logic [2:0] set_b, input logic [2:0] clr_b);
        valid_i        = v;
        data_i         = {d2, d1, d0};
        set_broken_i   = set_b;
        clear_broken_i = clr_b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        valid_i = 1'b0;
        data_i = '0;
        set_broken_i = '0;
        clear_broken_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", 32'(valid_o), 32'd0);
        checkOutput("reset_data", data_o, 32'd0);
        checkOutput("reset_broken", 32'(is_broken_o), 32'd0);
        checkOutput("reset_degraded", 32'(degraded_o), 32'd0);
        checkOutput("reset_fatal", 32'(fatal_o), 32'd0);
        rst = 1'b0;

        applyStimulus(1, 5, 5, 5, 3'b000, 3'b000);
        checkOutput("clean_data", data_o, 32'd5);
        checkOutput("clean_valid", 32'(valid_o), 32'd1);
        checkOutput("clean_errs", {29'd0, err_detected_o, err_corrected_o, err_uncorrectable_o}, 32'd0);
        checkOutput("clean_broken", 32'(is_broken_o), 32'd0);

        applyStimulus(1, 1, 0, 0, 3'b000, 3'b000);
        checkOutput("upset_data", data_o, 32'd0);
        checkOutput("upset_det", 32'(err_detected_o), 32'd1);
        checkOutput("upset_cor", 32'(err_corrected_o), 32'd1);
        checkOutput("upset_unc", 32'(err_uncorrectable_o), 32'd0);
        checkOutput("upset_cnt2", 32'(dut.mis_cnt_q[2]), 32'd1);

        applyStimulus(1, 1, 0, 0, 3'b000, 3'b000);
        applyStimulus(1, 1, 0, 0, 3'b000, 3'b000);
        checkOutput("retire_not_yet", 32'(is_broken_o), 32'b000);
        applyStimulus(1, 1, 0, 0, 3'b000, 3'b000);
        checkOutput("retire_broken", 32'(is_broken_o), 32'b100);
        checkOutput("retire_degraded", 32'(degraded_o), 32'd1);
        applyStimulus(1, 1, 0, 0, 3'b000, 3'b000);
        checkOutput("retired_det", 32'(err_detected_o), 32'd0);
        checkOutput("retired_data", data_o, 32'd0);

        applyStimulus(0, 0, 0, 0, 3'b000, 3'b100);
        checkOutput("clear_ch2", 32'(is_broken_o), 32'b000);
        checkOutput("clear_degraded", 32'(degraded_o), 32'd0);
        checkOutput("idle_valid", 32'(valid_o), 32'd0);

        applyStimulus(1, 0, 0, 7, 3'b000, 3'b000);
        checkOutput("leak_cnt0_up", 32'(dut.mis_cnt_q[0]), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 3'b000, 3'b000);
        checkOutput("leak_cnt0_hold", 32'(dut.mis_cnt_q[0]), 32'd1);
        applyStimulus(1, 0, 0, 0, 3'b000, 3'b000);
        checkOutput("leak_cnt0_down", 32'(dut.mis_cnt_q[0]), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 7, 3'b000, 3'b000);
        checkOutput("leak_cnt0_three", 32'(dut.mis_cnt_q[0]), 32'd3);
        checkOutput("leak_not_broken", 32'(is_broken_o), 32'b000);

        applyStimulus(0, 0, 0, 0, 3'b100, 3'b001);
        checkOutput("tie_setup_broken", 32'(is_broken_o), 32'b100);
        applyStimulus(1, 32'h55, 32'hF, 32'h0, 3'b000, 3'b000);
        checkOutput("tie_data", data_o, 32'h0);
        checkOutput("tie_unc", 32'(err_uncorrectable_o), 32'd1);
        checkOutput("tie_cor", 32'(err_corrected_o), 32'd0);
        checkOutput("tie_det", 32'(err_detected_o), 32'd1);
        checkOutput("tie_cnt1", 32'(dut.mis_cnt_q[1]), 32'd1);

        applyStimulus(0, 0, 0, 0, 3'b010, 3'b000);
        applyStimulus(1, 32'hA, 32'hB, 32'h1234, 3'b000, 3'b000);
        checkOutput("single_data", data_o, 32'h1234);
        checkOutput("single_det", 32'(err_detected_o), 32'd0);
        checkOutput("single_degraded", 32'(degraded_o), 32'd1);
        checkOutput("single_fatal", 32'(fatal_o), 32'd0);

        applyStimulus(0, 0, 0, 0, 3'b111, 3'b000);
        checkOutput("hold_data", data_o, 32'h1234);
        checkOutput("fatal_flag", 32'(fatal_o), 32'd1);
        applyStimulus(1, 9, 9, 9, 3'b000, 3'b000);
        checkOutput("fatal_data", data_o, 32'd0);
        checkOutput("fatal_valid", 32'(valid_o), 32'd1);

        applyStimulus(0, 0, 0, 0, 3'b010, 3'b111);
        checkOutput("set_wins", 32'(is_broken_o), 32'b010);
        checkOutput("set_wins_fatal", 32'(fatal_o), 32'd0);
        applyStimulus(0, 0, 0, 0, 3'b000, 3'b111);
        checkOutput("clear_all", 32'(is_broken_o), 32'b000);
        checkOutput("clear_all_degraded", 32'(degraded_o), 32'd0);

        applyStimulus(0, 0, 0, 0, 3'b100, 3'b000);
        applyStimulus(1, 3, 3, 3, 3'b000, 3'b000);
        checkOutput("pre_rst_data", data_o, 32'd3);
        rst = 1'b1;
        applyStimulus(1, 7, 0, 0, 3'b001, 3'b000);
        rst = 1'b0;
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_data", data_o, 32'd0);
        checkOutput("rst_broken", 32'(is_broken_o), 32'b000);
        checkOutput("rst_degraded", 32'(degraded_o), 32'd0);
        checkOutput("rst_errs", {29'd0, err_detected_o, err_corrected_o, err_uncorrectable_o}, 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
